fifocntl_txpack: RTL
====================

Name: fifocntl_txpack

Overview:
Upstream neighbour of the 10GbE TX FIFO. It accepts one outbound frame from the NPU core as a 32-bit AXI4-Stream, packs it into a single 1048-bit TX FIFO entry, and writes that entry when the FIFO has room.
- Entry layout: bits [7:0] length control, bits [23:8] destination, bits [1047:24] payload (4 x 256-bit beats).
- The FIFO's read side feeds the 256-bit AXI4 transmit controller, which decodes the length control into tkeep/tlast and byte count.

Parameters:
CNT_W, 16, width of the sent/dropped frame counters (wrap-around).

Ports:
inclk  in  1  clock
inrst  in  1  reset; asynchronous assert, active-low
s_tdata  in  32  frame word; byte0 = bits [7:0]
s_tkeep  in  4  byte enables; contiguous-low on last word, 4'b1111 otherwise
s_tuser  in  16  destination; sampled on first word only
s_tvalid  in  1  word valid
s_tlast  in  1  last word of frame
s_tready  out  1  block accepts word
txfifofull  in  1  TX FIFO full
txfifowe  out  1  TX FIFO write strobe (one cycle per frame)
txfifo_din  out  1048  packed entry
frames_sent  out  CNT_W  committed-frame counter
frames_dropped  out  CNT_W  dropped-frame counter
err  out  1  sticky; set on any drop, cleared only by reset

Behaviour:
- Reset (inrst=0, asynchronous): state=IDLE, staging buffer=0, word index=0, txfifowe=0, s_tready=0 while inrst is low, counters=0, err=0. A partial frame is discarded and no write occurs.
- A word is accepted when s_tvalid & s_tready on a rising edge.
- States:
  - IDLE: s_tready=1.
    - First accepted word: clear the payload buffer to 0, latch s_tuser as destination, store word at index 0, idx=1.
    - If s_tlast is also set, compute length and go to COMMIT; otherwise go to COLLECT.
  - COLLECT: s_tready=1.
    - Each accepted word k is stored at payload bits [24+32k +: 32], then idx increments.
    - On tlast: compute length and go to COMMIT.
    - Word number 33 (idx==32 with s_tvalid): go to DISCARD; if that word also carries tlast, go straight to IDLE with a drop.
  - COMMIT: s_tready=0; txfifowe = !txfifofull (combinational).
    - When txfifowe=1: the entry is written on that edge, frames_sent++, next state IDLE.
    - While full: hold, with txfifo_din stable.
  - DISCARD: s_tready=1; sink words until tlast is accepted, then frames_dropped++, err=1, go to IDLE.
- Length rule:
  - bytes = 4*(words-1) + ones(last tkeep), range 1..128.
  - ctl = bytes-1; [7]=0, [6:5] = index of last 256-bit beat, [4:0] = last byte index in that beat.
  - Byte count can be recovered downstream as 32*[6:5] + [4:0] + 1.
- Bad tkeep:
  - Non-contiguous or zero tkeep on the last word, or tkeep != 4'b1111 on a non-last word, marks the frame bad.
  - A bad frame is not committed: frames_dropped++, err=1, and the block returns to IDLE after tlast (via DISCARD if tlast not yet seen).
- Unwritten payload bytes (unused words, and masked bytes of the last word) are 0 in txfifo_din.
- txfifo_din = {payload, dest, ctl}, registered and held from COMMIT entry until the write.
- Latency: tlast accepted at edge N gives COMMIT during cycle N+1. With FIFO not full, txfifowe=1 in cycle N+1 and s_tready=1 again from cycle N+2.
- Back-to-back throughput: 1 frame per (words+1) cycles.
- Counters wrap from all-ones to 0.

Decomposition:
- Shared package fifocntl_pkg holds:
  - constants ENTRY_W=1048, CTL_W=8, DEST_W=16, BEAT_W=256, MAX_WORDS=32;
  - field offsets CTL_LSB=0, DEST_LSB=8, PAYLOAD_LSB=24;
  - state encoding IDLE/COLLECT/COMMIT/DISCARD.
  The TX controller and a future RX unpacker share this package.
- One sub-module, txpack_len: combinational; takes word count and last tkeep, returns ctl[7:0] and a bad_keep flag.

Test Plan:
- 1 word, tkeep=4'b0001, tuser=16'h1234, FIFO not full -> txfifowe 1 cycle after tlast; din[7:0]=8'h00, din[23:8]=16'h1234, din[31:24]=byte0, rest 0; frames_sent=1.
- 8 words, last tkeep=4'b0111 (31 bytes) -> ctl=8'h1E.
- 32 words, all 4'b1111 (128 bytes) -> ctl=8'h7F, payload fully populated.
- 9 words, last tkeep=4'b0001 (33 bytes) -> ctl=8'h20.
- txfifofull=1 for 5 cycles after tlast -> s_tready=0 and din stable throughout; txfifowe only on the first not-full cycle.
- Boundary/error cases:
  - 40-word frame -> no write, frames_dropped=1, err=1.
  - Last tkeep=4'b0101 -> dropped, err=1.
  - inrst pulsed low mid-frame -> no write; next frame packs correctly from word 0.

Source files
------------

// File: rtl/fifocntl_pkg.sv
// ============================================================================
// fifocntl_pkg : TX/RX FIFO entry layout and packer state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package fifocntl_pkg;

    localparam int ENTRY_W     = 1048;
    localparam int CTL_W       = 8;
    localparam int DEST_W      = 16;
    localparam int BEAT_W      = 256;
    localparam int MAX_WORDS   = 32;
    localparam int WORD_W      = 32;
    localparam int IDX_W       = 6;

    localparam int CTL_LSB     = 0;
    localparam int DEST_LSB    = 8;
    localparam int PAYLOAD_LSB = 24;
    localparam int PAYLOAD_W   = 4 * BEAT_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] COMMIT  = 2'd2;
    localparam logic [1:0] DISCARD = 2'd3;

endpackage

`default_nettype wire

// File: rtl/txpack_len.sv
// ============================================================================
// txpack_len : frame length control byte and last-word tkeep validity check
// Rev 1.0
// ============================================================================
`default_nettype none

module txpack_len
    import fifocntl_pkg::*;
(
    input  logic [IDX_W-1:0] words,
    input  logic [3:0]       last_keep,
    output logic [CTL_W-1:0] ctl,
    output logic             bad_keep
);

    logic [2:0]       w_ones;
    logic [IDX_W-1:0] w_words_m1;
    logic [6:0]       w_last_idx;

    always_comb begin
        w_ones   = 3'($countones(last_keep));
        bad_keep = 1'b0;
        unique case (last_keep)
            4'b0001, 4'b0011, 4'b0111, 4'b1111: bad_keep = 1'b0;
            default:                            bad_keep = 1'b1;
        endcase
    end

    // bytes-1 already splits as {beat index, byte-in-beat} since a beat is 32 bytes
    assign w_words_m1 = words - 6'd1;
    assign w_last_idx = 7'({w_words_m1, 2'b00}) + 7'(w_ones) - 7'd1;
    assign ctl        = {1'b0, w_last_idx};

endmodule

`default_nettype wire

// File: rtl/fifocntl_txpack.sv
// ============================================================================
// fifocntl_txpack : packs one 32-bit AXI4-Stream frame into a 1048-bit TX FIFO entry
// Rev 1.0
// ============================================================================
`default_nettype none

module fifocntl_txpack
    import fifocntl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               inclk,
    input  logic               inrst,
    input  logic [31:0]        s_tdata,
    input  logic [3:0]         s_tkeep,
    input  logic [15:0]        s_tuser,
    input  logic               s_tvalid,
    input  logic               s_tlast,
    output logic               s_tready,
    input  logic               txfifofull,
    output logic               txfifowe,
    output logic [ENTRY_W-1:0] txfifo_din,
    output logic [CNT_W-1:0]   frames_sent,
    output logic [CNT_W-1:0]   frames_dropped,
    output logic               err
);

    logic [1:0]           r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [DEST_W-1:0]    r_dest;
    logic [CTL_W-1:0]     r_ctl;
    logic [CNT_W-1:0]     r_sent;
    logic [CNT_W-1:0]     r_dropped;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_keep_full;
    logic [IDX_W-1:0]     w_words;
    logic [CTL_W-1:0]     w_ctl;
    logic                 w_bad_keep;
    logic [WORD_W-1:0]    w_wdata;

    assign s_tready    = inrst & (r_state != COMMIT);
    assign txfifowe    = (r_state == COMMIT) & ~txfifofull;
    assign w_accept    = s_tvalid & s_tready;
    assign w_keep_full = (s_tkeep == 4'b1111);
    assign w_words     = (r_state == IDLE) ? 6'd1 : r_idx + 6'd1;

    // Masked bytes are stored as zero so the entry never carries stale data
    for (genvar b = 0; b < 4; b++) begin : g_mask
        assign w_wdata[8*b +: 8] = s_tkeep[b] ? s_tdata[8*b +: 8] : 8'h00;
    end

    txpack_len u_len (
        .words     (w_words),
        .last_keep (s_tkeep),
        .ctl       (w_ctl),
        .bad_keep  (w_bad_keep)
    );

    always_ff @(posedge inclk or negedge inrst) begin
        if (!inrst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_payload <= '0;
            r_dest    <= '0;
            r_ctl     <= '0;
            r_sent    <= '0;
            r_dropped <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_payload <= {{(PAYLOAD_W-WORD_W){1'b0}}, w_wdata};
                        r_dest    <= s_tuser;
                        r_idx     <= 6'd1;
                        if (s_tlast) begin
                            if (w_bad_keep) begin
                                r_dropped <= r_dropped + CNT_W'(1);
                                r_err     <= 1'b1;
                                r_state   <= IDLE;
                            end else begin
                                r_ctl   <= w_ctl;
                                r_state <= COMMIT;
                            end
                        end else if (!w_keep_full) begin
                            r_state <= DISCARD;
                        end else begin
                            r_state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (w_accept) begin
                        if (r_idx == 6'(MAX_WORDS)) begin
                            if (s_tlast) begin
                                r_dropped <= r_dropped + CNT_W'(1);
                                r_err     <= 1'b1;
                                r_state   <= IDLE;
                            end else begin
                                r_state <= DISCARD;
                            end
                        end else begin
                            r_payload[{r_idx[4:0], 5'b00000} +: WORD_W] <= w_wdata;
                            r_idx <= r_idx + 6'd1;
                            if (s_tlast) begin
                                if (w_bad_keep) begin
                                    r_dropped <= r_dropped + CNT_W'(1);
                                    r_err     <= 1'b1;
                                    r_state   <= IDLE;
                                end else begin
                                    r_ctl   <= w_ctl;
                                    r_state <= COMMIT;
                                end
                            end else if (!w_keep_full) begin
                                r_state <= DISCARD;
                            end
                        end
                    end
                end
                COMMIT: begin
                    if (!txfifofull) begin
                        r_sent  <= r_sent + CNT_W'(1);
                        r_state <= IDLE;
                    end
                end
                DISCARD: begin
                    if (w_accept && s_tlast) begin
                        r_dropped <= r_dropped + CNT_W'(1);
                        r_err     <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign txfifo_din[CTL_LSB     +: CTL_W]     = r_ctl;
    assign txfifo_din[DEST_LSB    +: DEST_W]    = r_dest;
    assign txfifo_din[PAYLOAD_LSB +: PAYLOAD_W] = r_payload;

    assign frames_sent    = r_sent;
    assign frames_dropped = r_dropped;
    assign err            = r_err;

endmodule

`default_nettype wire
